// File: rtl/channel_sample_pkg.sv
// Shared types, frame layout and helpers for the channel sample master.
package channel_sample_pkg;

    // Sampler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    // Frame layout: sequence number in the low byte, channels above it
    localparam int SEQ_W   = 8;
    localparam int SEQ_LSB = 0;

    // Bit offset of channel k inside a frame
    function automatic int ch_lsb(input int k, input int data_w);
        return SEQ_LSB + SEQ_W + k * data_w;
    endfunction

    // Channel-select width; a single channel still needs one select bit
    function automatic int chsel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Effective sample period: never shorter than one full frame (2 cycles
    // per channel) plus the IDLE cycle, so a tick always finds the FSM idle
    function automatic logic [31:0] eff_period(input logic [31:0] period, input int num_ch);
        logic [31:0] min_p;
        min_p = 32'(2 * num_ch + 1);
        if (period < min_p) begin
            return min_p;
        end else begin
            return period;
        end
    endfunction

    // 8-bit saturating add of a small increment
    function automatic logic [7:0] sat_add8(input logic [7:0] value, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, value} + {7'd0, inc};
        if (sum > 9'd255) begin
            return 8'd255;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/channel_sample_fifo.sv
// First-word fall-through frame FIFO. DEPTH must be a power of two (>= 2).
// A push while full is only accepted when a pop happens in the same cycle.
module channel_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Flags, accepted push/pop, and head word (zero while empty)
    always_comb begin
        full    = (count_r == (AW+1)'(DEPTH));
        empty   = (count_r == '0);
        rd_en_s = pop && !empty;
        wr_en_s = push && (!full || rd_en_s);
        if (empty) begin
            pop_data = '0;
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a new word is visible one cycle after its push
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/channel_sample_master.sv
// Fixed-rate Avalon-MM poller: reads one sample per channel on every divider
// tick, packs them with a sequence number and queues the frame for streaming.
module channel_sample_master
    import channel_sample_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [DIV_W-1:0]                  period,
    output logic [1:0]                        avm_address,
    output logic [chsel_w(NUM_CH)-1:0]        avm_chsel,
    output logic                              avm_read,
    input  logic [31:0]                       avm_readdata,
    output logic [NUM_CH*DATA_W+SEQ_W-1:0]    src_data,
    output logic                              src_valid,
    input  logic                              src_ready,
    output logic [7:0]                        overrun_cnt,
    output logic                              busy
);
    localparam int CHSEL_W = chsel_w(NUM_CH);
    localparam int FRAME_W = NUM_CH * DATA_W + SEQ_W;

    logic [DIV_W-1:0]         div_cnt_r;
    logic [DIV_W-1:0]         reload_s;
    logic                     div_run_s;
    logic                     tick_s;
    state_e                   state_r;
    state_e                   state_s;
    logic [CHSEL_W-1:0]       ch_r;
    logic [CHSEL_W-1:0]       ch_s;
    logic                     capt_s;
    logic                     push_s;
    logic                     skip_s;
    logic                     drop_s;
    logic                     pop_s;
    logic [1:0]               ovr_inc_s;
    logic [NUM_CH*DATA_W-1:0] slot_r;
    logic [SEQ_W-1:0]         seq_r;
    logic [7:0]               overrun_r;
    logic [FRAME_W-1:0]       frame_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     avm_read_r;
    logic [CHSEL_W-1:0]       avm_chsel_r;
    logic                     busy_r;
    logic                     unused_rdata_s;

    assign unused_rdata_s = ^avm_readdata[31:DATA_W];

    // Divider control: reload value and tick when the running counter hits 0
    always_comb begin
        reload_s  = DIV_W'(eff_period(32'(period), NUM_CH) - 32'd1);
        div_run_s = enable && (period != '0);
        tick_s    = div_run_s && (div_cnt_r == '0);
    end

    // Sample-period down-counter; held at reload while stopped or in reset
    always_ff @(posedge clk) begin
        if (!reset_n || !div_run_s) begin
            div_cnt_r <= reload_s;
        end else if (div_cnt_r == '0) begin
            div_cnt_r <= reload_s;
        end else begin
            div_cnt_r <= div_cnt_r - DIV_W'(1);
        end
    end

    // FSM next state: ADDR/CAPT pair per channel, push after the last CAPT
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        capt_s  = 1'b0;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_s = ST_ADDR;
                    ch_s    = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_CAPT;
            end
            ST_CAPT: begin
                capt_s = 1'b1;
                if (ch_r == CHSEL_W'(NUM_CH - 1)) begin
                    push_s  = 1'b1;
                    state_s = ST_IDLE;
                    ch_s    = '0;
                end else begin
                    ch_s    = ch_r + CHSEL_W'(1);
                    state_s = ST_ADDR;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = '0;
            end
        endcase
    end

    // Overrun sources: ticks landing mid-frame and frames refused by a full FIFO
    always_comb begin
        skip_s    = tick_s && (state_r != ST_IDLE);
        pop_s     = src_ready && !fifo_empty_s;
        drop_s    = push_s && fifo_full_s && !pop_s;
        ovr_inc_s = {1'b0, skip_s} + {1'b0, drop_s};
    end

    // FSM state plus bus outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ch_r        <= '0;
            avm_read_r  <= 1'b0;
            avm_chsel_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ch_r        <= ch_s;
            avm_read_r  <= (state_s == ST_ADDR);
            avm_chsel_r <= ch_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Sample capture: readdata is valid in CAPT for the channel addressed in ADDR
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_r <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (capt_s && (ch_r == CHSEL_W'(k))) begin
                    slot_r[k*DATA_W +: DATA_W] <= avm_readdata[DATA_W-1:0];
                end
            end
        end
    end

    // Frame assembly; the last channel comes straight from the bus in its CAPT
    always_comb begin
        frame_s = '0;
        frame_s[SEQ_LSB +: SEQ_W] = seq_r;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == NUM_CH - 1) begin
                frame_s[ch_lsb(k, DATA_W) +: DATA_W] = avm_readdata[DATA_W-1:0];
            end else begin
                frame_s[ch_lsb(k, DATA_W) +: DATA_W] = slot_r[k*DATA_W +: DATA_W];
            end
        end
    end

    // Sequence counts every completed frame (dropped ones too); overrun saturates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_r     <= '0;
            overrun_r <= 8'd0;
        end else begin
            if (push_s) begin
                seq_r <= seq_r + SEQ_W'(1);
            end
            overrun_r <= sat_add8(overrun_r, ovr_inc_s);
        end
    end

    channel_sample_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (frame_s),
        .pop       (src_ready),
        .pop_data  (src_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign avm_address = 2'b00;
    assign avm_chsel   = avm_chsel_r;
    assign avm_read    = avm_read_r;
    assign src_valid   = !fifo_empty_s;
    assign overrun_cnt = overrun_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_channel_sample_master.sv
// Bench for channel_sample_master: frame-level reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_channel_sample_master;
    localparam int NUM_CH     = 3;
    localparam int DATA_W     = 8;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int FW         = NUM_CH * DATA_W + 8;
    localparam int CW         = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  period = 16'd10;
    logic [1:0]        avm_address;
    logic [CW-1:0]     avm_chsel;
    logic              avm_read;
    logic [31:0]       avm_readdata = 32'd0;
    logic [FW-1:0]     src_data;
    logic              src_valid;
    logic              src_ready = 1'b0;
    logic [7:0]        overrun_cnt;
    logic              busy;

    channel_sample_master #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
        .avm_address(avm_address), .avm_chsel(avm_chsel), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .overrun_cnt(overrun_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // PIO slaves behind the mux: readdata registered one cycle after chsel
    logic [NUM_CH*8-1:0] slave_vals = '0;
    logic [NUM_CH*8-1:0] fixed_vals = '0;
    logic                rand_mode  = 1'b0;
    always @(posedge clk) begin
        if (int'(avm_chsel) < NUM_CH)
            avm_readdata <= {24'($urandom), slave_vals[int'(avm_chsel)*8 +: 8]};
        else
            avm_readdata <= {24'($urandom), 8'hEE};
    end
    always @(posedge clk) begin
        #1;
        if (rand_mode) slave_vals = 24'($urandom);
        else           slave_vals = fixed_vals;
    end

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int phase = 0;
    int t_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int eff(input int p);
        return (p < 2*NUM_CH+1) ? 2*NUM_CH+1 : p;
    endfunction

    // Reference model state
    logic          model_ok = 1'b0;
    logic          prev_rst = 1'b0;
    logic          act = 1'b0;
    int            t0 = 0;
    logic          armed = 1'b0;
    int            next_tick = 0;
    int            period_prev = 10;
    logic [7:0]    mseq = 8'd0;
    int            ovr = 0;
    logic [7:0]    msamp [NUM_CH];
    logic [FW-1:0] q [$];
    int            pop_idx = 0;
    int            rd_after = 0;
    int            bp_seq [5] = '{0, 1, 2, 3, 6};

    // Compare DUT against the model, then advance the model by one cycle
    always @(negedge clk) begin
        int d;
        logic eb, popm, fullm, tickm, enm;
        logic [FW-1:0] f;
        d  = cyc - t0;
        eb = act && (d >= 1) && (d <= 2*NUM_CH);
        if (model_ok) begin
            chk("busy", 64'(busy), 64'(eb));
            chk("avm_read", 64'(avm_read), 64'(eb && (d % 2 == 1)));
            if (eb) chk("avm_chsel", 64'(avm_chsel), 64'((d - 1) / 2));
            chk("avm_address", 64'(avm_address), 64'd0);
            chk("src_valid", 64'(src_valid), 64'(q.size() > 0));
            if (q.size() > 0) chk("src_data", 64'(src_data), 64'(q[0]));
            chk("overrun_cnt", 64'(overrun_cnt), 64'(ovr));
            if (prev_rst) begin
                chk("rst_read", 64'(avm_read), 64'd0);
                chk("rst_chsel", 64'(avm_chsel), 64'd0);
                chk("rst_valid", 64'(src_valid), 64'd0);
                chk("rst_data", 64'(src_data), 64'd0);
                chk("rst_overrun", 64'(overrun_cnt), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
            end
            case (phase)
                1: begin
                    if (cyc == t_en + 10) chk("basic_addr0", 64'(avm_read), 64'd1);
                    if (cyc == t_en + 15) chk("basic_not_yet", 64'(src_valid), 64'd0);
                    if (cyc == t_en + 16) begin
                        chk("basic_valid_t7", 64'(src_valid), 64'd1);
                        chk("basic_frame0", 64'(src_data), 64'h33221100);
                    end
                    if (cyc == t_en + 25) chk("basic_gap", 64'(src_valid), 64'd0);
                    if (cyc == t_en + 26) chk("basic_frame1", 64'(src_data), 64'h33221101);
                end
                2: begin
                    if (cyc == t_en + 7)  chk("clamp_read0", 64'(avm_read), 64'd1);
                    if (cyc == t_en + 13) chk("clamp_idle", 64'(avm_read), 64'd0);
                    if (cyc == t_en + 14) chk("clamp_read1", 64'(avm_read), 64'd1);
                    if (cyc == t_en + 21) chk("clamp_read2", 64'(avm_read), 64'd1);
                    if (cyc == t_en + 40) chk("clamp_overrun", 64'(overrun_cnt), 64'd0);
                end
                3: begin
                    if (cyc == t_en) pop_idx = 0;
                    if (cyc == t_en + 70) chk("bp_overrun", 64'(overrun_cnt), 64'd2);
                    if (src_valid && src_ready && pop_idx < 5) begin
                        chk("bp_pop_seq", 64'(src_data[7:0]), 64'(bp_seq[pop_idx]));
                        pop_idx++;
                    end
                    if (cyc == t_en + 88) chk("bp_pop_count", 64'(pop_idx), 64'd5);
                end
                4: begin
                    if (cyc == t_en + 40) chk("fwp_head0", 64'(src_data[7:0]), 64'd0);
                    if (cyc == t_en + 41) begin
                        chk("fwp_head1", 64'(src_data[7:0]), 64'd1);
                        chk("fwp_no_drop", 64'(overrun_cnt), 64'd0);
                    end
                    if (cyc == t_en + 50) chk("fwp_overrun", 64'(overrun_cnt), 64'd0);
                end
                5: begin
                    if (cyc == t_en) rd_after = 0;
                    if (cyc == t_en + 13) chk("endrop_capt1", 64'({busy, avm_read}), 64'b10);
                    if (cyc == t_en + 16) chk("endrop_frame", 64'(src_data), 64'hC35AA500);
                    if (cyc > t_en + 16 && avm_read) rd_after++;
                    if (cyc == t_en + 60) chk("endrop_no_read", 64'(rd_after), 64'd0);
                end
                6: begin
                    if (cyc == t_en + 14)
                        chk("rstmid_addr2", 64'({busy, avm_read, avm_chsel}), 64'b1110);
                end
                7: begin
                    if (cyc == t_en + 16) chk("rstmid_seq0", 64'(src_data), 64'h33221100);
                end
                8: begin
                    if (cyc == t_en + 1900) chk("sat_overrun", 64'(overrun_cnt), 64'd255);
                end
                default: ;
            endcase
        end
        if (!reset_n) begin
            act = 1'b0; mseq = 8'd0; q.delete(); ovr = 0; armed = 1'b0;
            model_ok = 1'b1; prev_rst = 1'b1;
        end else if (model_ok) begin
            prev_rst = 1'b0;
            popm  = (q.size() > 0) && src_ready;
            fullm = (q.size() == FIFO_DEPTH);
            enm   = enable && (period != 0);
            tickm = 1'b0;
            if (!enm) armed = 1'b0;
            else if (!armed) begin
                armed = 1'b1;
                next_tick = cyc + eff(period_prev) - 1;
            end else if (cyc == next_tick) begin
                tickm = 1'b1;
                next_tick = cyc + eff(int'(period));
            end
            if (eb && (d % 2 == 1)) msamp[(d-1)/2] = slave_vals[((d-1)/2)*8 +: 8];
            if (popm) void'(q.pop_front());
            if (eb && d == 2*NUM_CH) begin
                f = '0;
                f[7:0] = mseq;
                for (int k = 0; k < NUM_CH; k++) f[8 + 8*k +: 8] = msamp[k];
                if (!fullm || popm) q.push_back(f);
                else if (ovr < 255) ovr++;
                mseq = mseq + 8'd1;
                act = 1'b0;
            end
            if (tickm) begin
                if (eb) begin
                    if (ovr < 255) ovr++;
                end else begin
                    act = 1'b1;
                    t0 = cyc;
                end
            end
        end
        period_prev = int'(period);
        cyc++;
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input int ph, input int per, input logic rdy);
        phase = 0;
        period = DIV_W'(per);
        src_ready = rdy;
        reset_n = 1'b0;
        enable = 1'b0;
        step(2);
        reset_n = 1'b1;
        enable = 1'b1;
        t_en = cyc;
        phase = ph;
    endtask

    initial begin
        int ready_pct;
        fixed_vals = 24'h332211;
        start_phase(1, 10, 1'b1);
        wait_cyc(t_en + 30);

        start_phase(2, 2, 1'b1);
        wait_cyc(t_en + 45);

        start_phase(3, 10, 1'b0);
        wait_cyc(t_en + 70); src_ready = 1'b1;
        wait_cyc(t_en + 78); enable = 1'b0;
        wait_cyc(t_en + 90);

        start_phase(4, 2, 1'b0);
        wait_cyc(t_en + 40); src_ready = 1'b1;
        step(1);             src_ready = 1'b0;
        wait_cyc(t_en + 45); enable = 1'b0; src_ready = 1'b1;
        wait_cyc(t_en + 62);

        fixed_vals = 24'hC35AA5;
        start_phase(5, 10, 1'b1);
        wait_cyc(t_en + 13); enable = 1'b0;
        wait_cyc(t_en + 62);

        fixed_vals = 24'h332211;
        start_phase(6, 10, 1'b1);
        wait_cyc(t_en + 14); reset_n = 1'b0; enable = 1'b0;
        step(2);
        reset_n = 1'b1; enable = 1'b1; t_en = cyc; phase = 7;
        wait_cyc(t_en + 30);

        start_phase(8, 2, 1'b0);
        wait_cyc(t_en + 1905);

        rand_mode = 1'b1;
        start_phase(9, 10, 1'b1);
        ready_pct = 70;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) ready_pct = $urandom_range(0, 100);
            src_ready = ($urandom_range(0, 99) < ready_pct);
            if ($urandom_range(0, 59) == 0) period = DIV_W'($urandom_range(0, 24));
            if ($urandom_range(0, 99) == 0) enable = !enable;
            reset_n = ($urandom_range(0, 799) != 0);
            step(1);
        end
        reset_n = 1'b1;
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
